// File: rtl/dma_copy_pkg.sv
// Shared definitions for the dma_copy word-copy engine: register map, CTRL bit positions,
// FSM state encoding and the byte-lane merge helper.
package dma_copy_pkg;

  localparam logic [1:0] RegSrc  = 2'd0;
  localparam logic [1:0] RegDst  = 2'd1;
  localparam logic [1:0] RegLen  = 2'd2;
  localparam logic [1:0] RegCtrl = 2'd3;

  localparam int unsigned CtrlStart   = 0;
  localparam int unsigned CtrlBusy    = 1;
  localparam int unsigned CtrlDone    = 2;
  localparam int unsigned CtrlErr     = 3;
  localparam int unsigned CtrlIe      = 4;
  localparam int unsigned CtrlAbort   = 5;
  localparam int unsigned CtrlAborted = 6;

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  function automatic logic [31:0] apply_wsel(input logic [31:0] cur, input logic [31:0] wdata,
                                             input logic [3:0] wsel);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (wsel[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dma_copy_regfile.sv
// Responder port and register file of dma_copy (SRC/DST/LEN/CTRL, W1C status bits).
// CTRL ABORT/ABORTED exist only when DMA_ABORT_EN is defined.
module dma_copy_regfile
  import dma_copy_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      dma_address,
  input  logic [31:0]      dma_wdata,
  input  logic [3:0]       dma_wsel,
  input  logic             dma_valid,
  output logic [31:0]      dma_rdata,
  output logic             dma_ready,
  output logic             dma_error,
  input  logic             busy,
  input  logic             beat_done,
  input  logic             set_done,
  input  logic             set_err,
  input  logic             set_aborted,
  output logic             start,
  output logic             abort,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [LEN_W-1:0] len,
  output logic             xint
);

  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             done_q, done_d, err_q, err_d, ie_q, ie_d;
  logic             ready_q, error_q;
  logic [31:0]      rdata_q, rd_word, ctrl_rd, len_wr;
  logic             accept, bad, wr, rd, ctrl_wr, start_req, zero_done;
  logic [1:0]       sel;
  logic             unused_addr;

  // A new request is only taken when no response is on the bus, giving one access per 2 cycles.
  assign accept    = dma_valid & ~(ready_q | error_q);
  assign bad       = |dma_address[7:4];
  assign sel       = dma_address[3:2];
  assign wr        = accept & ~bad & (|dma_wsel);
  assign rd        = accept & ~bad & ~(|dma_wsel);
  assign ctrl_wr   = wr & (sel == RegCtrl) & dma_wsel[0];
  assign start_req = ctrl_wr & dma_wdata[CtrlStart] & ~busy;
  assign start     = start_req & (len_q != '0);
  assign zero_done = start_req & (len_q == '0);
  assign len_wr    = apply_wsel(32'(len_q), dma_wdata, dma_wsel);

  assign unused_addr = ^{dma_address[31:8], dma_address[1:0]};

`ifdef DMA_ABORT_EN
  logic aborted_q, aborted_d;
  assign abort = ctrl_wr & dma_wdata[CtrlAbort] & busy;

  always_comb begin
    aborted_d = aborted_q;
    if (ctrl_wr && dma_wdata[CtrlAborted]) aborted_d = 1'b0;
    if (start) aborted_d = 1'b0;
    if (set_aborted) aborted_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) aborted_q <= 1'b0;
    else      aborted_q <= aborted_d;
  end
`else
  logic unused_abort;
  assign abort        = 1'b0;
  assign unused_abort = set_aborted;
`endif

  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    len_d  = len_q;
    done_d = done_q;
    err_d  = err_q;
    ie_d   = ie_q;
    if (wr && !busy) begin
      unique case (sel)
        RegSrc:  src_d = apply_wsel(src_q, dma_wdata, dma_wsel);
        RegDst:  dst_d = apply_wsel(dst_q, dma_wdata, dma_wsel);
        RegLen:  len_d = LEN_W'(len_wr);
        RegCtrl: ;
      endcase
    end
    if (beat_done) begin
      src_d = src_q + 32'd4;
      dst_d = dst_q + 32'd4;
      len_d = len_q - LEN_W'(1);
    end
    if (ctrl_wr) begin
      ie_d = dma_wdata[CtrlIe];
      if (dma_wdata[CtrlDone]) done_d = 1'b0;
      if (dma_wdata[CtrlErr])  err_d  = 1'b0;
    end
    if (start) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
    // Hardware set is applied last so it beats a simultaneous W1C.
    if (zero_done || set_done) done_d = 1'b1;
    if (set_err) err_d = 1'b1;
  end

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[CtrlBusy]    = busy;
    ctrl_rd[CtrlDone]    = done_q;
    ctrl_rd[CtrlErr]     = err_q;
    ctrl_rd[CtrlIe]      = ie_q;
`ifdef DMA_ABORT_EN
    ctrl_rd[CtrlAborted] = aborted_q;
`endif
    unique case (sel)
      RegSrc:  rd_word = src_q;
      RegDst:  rd_word = dst_q;
      RegLen:  rd_word = 32'(len_q);
      RegCtrl: rd_word = ctrl_rd;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ie_q    <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ie_q    <= ie_d;
      ready_q <= accept & ~bad;
      error_q <= accept & bad;
      rdata_q <= rd ? rd_word : '0;
    end
  end

  assign dma_ready = ready_q;
  assign dma_error = error_q;
  assign dma_rdata = rdata_q;
  assign src       = src_q;
  assign dst       = dst_q;
  assign len       = len_q;
  assign xint      = done_q & ie_q;

endmodule

// File: rtl/dma_copy.sv
// Memory-to-memory word-copy engine: register file plus a read-then-write initiator FSM.
// Optional CTRL ABORT/ABORTED support is enabled with DMA_ABORT_EN.
module dma_copy
  import dma_copy_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dma_address,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_wsel,
  input  logic        dma_valid,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic        dma_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wsel,
  output logic        mem_valid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        mem_error,
  output logic        xint_dma
);

  state_e           state_q;
  logic             abort_q;
  logic             busy, start, abort, abort_now, last;
  logic             beat_done, set_done, set_err, set_aborted;
  logic [31:0]      src, dst;
  logic [LEN_W-1:0] len;
  logic             unused_lsb;

  dma_copy_regfile #(
    .LEN_W(LEN_W)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .dma_address(dma_address),
    .dma_wdata  (dma_wdata),
    .dma_wsel   (dma_wsel),
    .dma_valid  (dma_valid),
    .dma_rdata  (dma_rdata),
    .dma_ready  (dma_ready),
    .dma_error  (dma_error),
    .busy       (busy),
    .beat_done  (beat_done),
    .set_done   (set_done),
    .set_err    (set_err),
    .set_aborted(set_aborted),
    .start      (start),
    .abort      (abort),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .xint       (xint_dma)
  );

  assign unused_lsb  = ^{src[1:0], dst[1:0]};
  assign busy        = (state_q != StIdle);
  assign abort_now   = abort_q | abort;
  assign last        = (len == LEN_W'(1));
  assign beat_done   = (state_q == StWr) & mem_valid & mem_ready & ~mem_error;
  assign set_err     = busy & mem_valid & mem_error;
  assign set_done    = beat_done & last & ~abort_now;
  // Abort lands at the end of the outstanding transfer, or at once in the gap between transfers.
  assign set_aborted = busy & abort_now & (~mem_valid | (mem_ready & ~mem_error));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      abort_q     <= 1'b0;
      mem_valid   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_wsel    <= '0;
    end else begin
      abort_q <= abort_q | abort;
      unique case (state_q)
        StIdle: begin
          abort_q <= 1'b0;
          if (start) begin
            state_q     <= StRd;
            mem_valid   <= 1'b1;
            mem_address <= {src[31:2], 2'b00};
            mem_wsel    <= 4'b0000;
          end
        end
        StRd: begin
          if (!mem_valid) begin
            if (abort_now) begin
              state_q <= StIdle;
              abort_q <= 1'b0;
            end else begin
              mem_valid <= 1'b1;
            end
          end else if (mem_error) begin
            state_q   <= StIdle;
            abort_q   <= 1'b0;
            mem_valid <= 1'b0;
          end else if (mem_ready) begin
            mem_valid <= 1'b0;
            if (abort_now) begin
              state_q <= StIdle;
              abort_q <= 1'b0;
            end else begin
              state_q     <= StWr;
              mem_address <= {dst[31:2], 2'b00};
              mem_wsel    <= 4'b1111;
              mem_wdata   <= mem_rdata;
            end
          end
        end
        StWr: begin
          if (!mem_valid) begin
            if (abort_now) begin
              state_q  <= StIdle;
              abort_q  <= 1'b0;
              mem_wsel <= 4'b0000;
            end else begin
              mem_valid <= 1'b1;
            end
          end else if (mem_error) begin
            state_q   <= StIdle;
            abort_q   <= 1'b0;
            mem_valid <= 1'b0;
            mem_wsel  <= 4'b0000;
          end else if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wsel  <= 4'b0000;
            if (last || abort_now) begin
              state_q <= StIdle;
              abort_q <= 1'b0;
            end else begin
              state_q     <= StRd;
              mem_address <= {src[31:2] + 30'd1, 2'b00};
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
// Self-checking bench for dma_copy: CPU register tasks, a memory responder model and a
// scoreboard queue of expected initiator writes.
module tb_dma_copy;

  localparam logic [31:0] ASrc  = 32'h0;
  localparam logic [31:0] ADst  = 32'h4;
  localparam logic [31:0] ALen  = 32'h8;
  localparam logic [31:0] ACtrl = 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dma_address, dma_wdata, dma_rdata;
  logic [3:0]  dma_wsel;
  logic        dma_valid, dma_ready, dma_error;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic [3:0]  mem_wsel;
  logic        mem_valid, mem_ready, mem_error;
  logic        xint_dma;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem[logic [31:0]];
  int          n_checks = 0;
  int          n_fail = 0;
  int          rd_count = 0;
  int          wr_count = 0;
  int          valid_rises = 0;
  int          err_rd_idx = -1;

  dma_copy u_dut (
    .clk        (clk),
    .rst        (rst),
    .dma_address(dma_address),
    .dma_wdata  (dma_wdata),
    .dma_wsel   (dma_wsel),
    .dma_valid  (dma_valid),
    .dma_rdata  (dma_rdata),
    .dma_ready  (dma_ready),
    .dma_error  (dma_error),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_wsel   (mem_wsel),
    .mem_valid  (mem_valid),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_error  (mem_error),
    .xint_dma   (xint_dma)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: answers each request on the second falling edge it is seen valid.
  initial begin : mem_model
    int          wait_cnt;
    logic        prev_valid;
    logic [31:0] a;
    wr_t         e;
    wait_cnt   = 0;
    prev_valid = 1'b0;
    mem_ready  = 1'b0;
    mem_error  = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_error = 1'b0;
      if (mem_valid && !prev_valid) valid_rises++;
      prev_valid = mem_valid;
      if (!rst || !mem_valid) begin
        wait_cnt = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          wait_cnt = 0;
          a = mem_address;
          if (mem_wsel == 4'b0000) begin
            if (rd_count == err_rd_idx) mem_error = 1'b1;
            else begin
              mem_rdata = mem.exists(a) ? mem[a] : 32'h0;
              mem_ready = 1'b1;
            end
            rd_count++;
          end else begin
            wr_count++;
            mem[a]    = mem_wdata;
            mem_ready = 1'b1;
            check_eq("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check_eq("wr_addr", a, e.addr);
              check_eq("wr_data", mem_wdata, e.data);
              check_eq("wr_wsel", 32'(mem_wsel), 32'hF);
            end
          end
        end
      end
    end
  end

  task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wsel, output logic rdy, output logic err,
                            output logic [31:0] rdata);
    @(negedge clk);
    dma_address = addr;
    dma_wdata   = wdata;
    dma_wsel    = wsel;
    dma_valid   = 1'b1;
    @(posedge clk);
    #1;
    rdy   = dma_ready;
    err   = dma_error;
    rdata = dma_rdata;
    @(negedge clk);
    dma_valid = 1'b0;
    dma_wsel  = 4'b0000;
  endtask

  task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
    logic r, e;
    logic [31:0] d;
    bus_access(addr, data, 4'hF, r, e, d);
  endtask

  task automatic reg_read(input logic [31:0] addr, output logic [31:0] data);
    logic r, e;
    bus_access(addr, 32'h0, 4'h0, r, e, data);
  endtask

  task automatic wait_idle();
    logic [31:0] c;
    c = 32'h2;
    for (int n = 0; n < 100 && c[1]; n++) reg_read(ACtrl, c);
    check_eq("idle_wait_busy", 32'(c[1]), 32'd0);
  endtask

  task automatic wait_mem_valid(input logic want_wr, input int want_wr_cnt);
    int n;
    for (n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (mem_valid && ((mem_wsel == 4'hF) == want_wr) && (!want_wr || wr_count == want_wr_cnt))
        break;
    end
    check_eq("mem_valid_wait", 32'(n < 200), 32'd1);
  endtask

  task automatic load_src(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) mem[base + 32'(4 * i)] = $urandom;
  endtask

  task automatic push_writes(input logic [31:0] s, input logic [31:0] d, input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = d + 32'(4 * i);
      e.data = mem[s + 32'(4 * i)];
      exp_q.push_back(e);
    end
  endtask

  initial begin : stim
    logic [31:0] v;
    logic        r, e;
    int          rises, wrs;

    rst         = 1'b0;
    dma_address = '0;
    dma_wdata   = '0;
    dma_wsel    = '0;
    dma_valid   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
    check_eq("rst_dma_ready", 32'(dma_ready), 32'd0);
    check_eq("rst_xint", 32'(xint_dma), 32'd0);
    for (int i = 0; i < 4; i++) begin
      reg_read(32'(4 * i), v);
      check_eq("rst_reg", v, 32'h0);
    end

    // Byte lanes and bad offsets.
    reg_write(ASrc, 32'hAABB_CCDD);
    bus_access(ASrc, 32'h1122_3344, 4'b0101, r, e, v);
    check_eq("wsel_ack", {30'b0, r, e}, 32'h2);
    reg_read(ASrc, v);
    check_eq("wsel_merge", v, 32'hAA22_CC44);
    bus_access(32'h10, 32'h0, 4'h0, r, e, v);
    check_eq("bad_rd_resp", {30'b0, r, e}, 32'h1);
    check_eq("bad_rd_data", v, 32'h0);
    bus_access(32'h20, 32'h5555_5555, 4'hF, r, e, v);
    check_eq("bad_wr_resp", {30'b0, r, e}, 32'h1);
    reg_read(ASrc, v);
    check_eq("bad_wr_no_effect", v, 32'hAA22_CC44);

    // Main copy of four words.
    load_src(32'h1000_0000, 4);
    push_writes(32'h1000_0000, 32'h1000_0100, 4);
    reg_write(ASrc, 32'h1000_0000);
    reg_write(ADst, 32'h1000_0100);
    reg_write(ALen, 32'd4);
    reg_write(ACtrl, 32'h1);
    reg_read(ACtrl, v);
    check_eq("job_busy", v, 32'h2);
    bus_access(ASrc, 32'hDEAD_0000, 4'hF, r, e, v);
    check_eq("busy_wr_ack", {30'b0, r, e}, 32'h2);
    wait_idle();
    reg_read(ACtrl, v);
    check_eq("job_ctrl_done", v, 32'h4);
    reg_read(ALen, v);
    check_eq("job_len", v, 32'h0);
    reg_read(ASrc, v);
    check_eq("job_src", v, 32'h1000_0010);
    reg_read(ADst, v);
    check_eq("job_dst", v, 32'h1000_0110);
    check_eq("job_writes_left", 32'(exp_q.size()), 32'd0);
    check_eq("job_rd_count", 32'(rd_count), 32'd4);
    check_eq("job_wr_count", 32'(wr_count), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq("job_dst_mem", mem[32'h1000_0100 + 32'(4 * i)], mem[32'h1000_0000 + 32'(4 * i)]);
    check_eq("xint_ie0", 32'(xint_dma), 32'd0);
    reg_write(ACtrl, 32'h10);
    check_eq("xint_ie1", 32'(xint_dma), 32'd1);
    reg_write(ACtrl, 32'h14);
    reg_read(ACtrl, v);
    check_eq("w1c_done", v, 32'h10);
    check_eq("xint_cleared", 32'(xint_dma), 32'd0);
    reg_write(ACtrl, 32'h0);

    // Zero-length job: done without any bus access.
    rises = valid_rises;
    reg_write(ALen, 32'd0);
    reg_write(ACtrl, 32'h1);
    reg_read(ACtrl, v);
    check_eq("zero_len_done", v, 32'h4);
    repeat (4) @(negedge clk);
    check_eq("zero_len_no_bus", 32'(valid_rises), 32'(rises));

    // Error on the second read of a three-word job.
    load_src(32'h2000_0000, 3);
    push_writes(32'h2000_0000, 32'h2000_0800, 1);
    wrs        = wr_count;
    err_rd_idx = rd_count + 1;
    reg_write(ASrc, 32'h2000_0000);
    reg_write(ADst, 32'h2000_0800);
    reg_write(ALen, 32'd3);
    reg_write(ACtrl, 32'h1);
    wait_idle();
    err_rd_idx = -1;
    reg_read(ACtrl, v);
    check_eq("err_ctrl", v, 32'h8);
    reg_read(ASrc, v);
    check_eq("err_src", v, 32'h2000_0004);
    reg_read(ALen, v);
    check_eq("err_len", v, 32'd2);
    check_eq("err_wr_count", 32'(wr_count - wrs), 32'd1);
    reg_write(ACtrl, 32'h8);
    reg_read(ACtrl, v);
    check_eq("w1c_err", v, 32'h0);

    // Reset in the middle of a read.
    reg_write(ASrc, 32'h3000_0000);
    reg_write(ADst, 32'h3000_0100);
    reg_write(ALen, 32'd2);
    reg_write(ACtrl, 32'h1);
    wait_mem_valid(1'b0, 0);
    rst = 1'b0;
    #1;
    check_eq("midrst_mem_valid", 32'(mem_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    rises = valid_rises;
    for (int i = 0; i < 4; i++) begin
      reg_read(32'(4 * i), v);
      check_eq("midrst_reg", v, 32'h0);
    end
    check_eq("midrst_no_bus", 32'(valid_rises), 32'(rises));

`ifdef DMA_ABORT_EN
    // Abort during the second write of an eight-word job.
    load_src(32'h4000_0000, 8);
    push_writes(32'h4000_0000, 32'h4000_0100, 2);
    wrs = wr_count;
    reg_write(ASrc, 32'h4000_0000);
    reg_write(ADst, 32'h4000_0100);
    reg_write(ALen, 32'd8);
    reg_write(ACtrl, 32'h1);
    wait_mem_valid(1'b1, wrs + 1);
    reg_write(ACtrl, 32'h20);
    wait_idle();
    reg_read(ACtrl, v);
    check_eq("abort_ctrl", v, 32'h40);
    reg_read(ALen, v);
    check_eq("abort_len", v, 32'd6);
    check_eq("abort_wr_count", 32'(wr_count - wrs), 32'd2);
    reg_write(ACtrl, 32'h40);
    reg_read(ACtrl, v);
    check_eq("w1c_aborted", v, 32'h0);
`else
    reg_write(ACtrl, 32'h60);
    reg_read(ACtrl, v);
    check_eq("no_abort_bits", v, 32'h0);
`endif

    repeat (4) @(negedge clk);
    check_eq("final_writes_left", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
